// File: rtl/serial_link_obi_arb_pkg.sv
// Shared types and helpers for the serial-link OBI arbiter.
// Flat OBI bundles plus index-width helper.
package serial_link_obi_arb_pkg;

    localparam int unsigned ObiAddrWidth = 32;
    localparam int unsigned ObiDataWidth = 32;
    localparam int unsigned ObiBeWidth   = ObiDataWidth / 8;

    typedef struct packed {
        logic                    req;
        logic [ObiAddrWidth-1:0] addr;
        logic                    we;
        logic [ObiBeWidth-1:0]   be;
        logic [ObiDataWidth-1:0] wdata;
    } obi_flat_req_t;

    typedef struct packed {
        logic                    gnt;
        logic                    rvalid;
        logic [ObiDataWidth-1:0] rdata;
    } obi_flat_rsp_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_link_obi_arb_idq.sv
// In-order queue of requester IDs for in-flight OBI transactions.
// Wrap-around pointers, occupancy counter drives full/empty.
module serial_link_obi_arb_idq
    import serial_link_obi_arb_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 1,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push,
    input  logic            pop,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] head,
    output logic            full,
    output logic            empty,
    output logic [CntW-1:0] count
);

    localparam int unsigned PtrW = idx_width(Depth);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wptr;
    logic [PtrW-1:0]  rptr;
    logic [CntW-1:0]  cnt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full    = (cnt == CntW'(Depth));
    assign empty   = (cnt == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rptr];
    assign count   = cnt;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                wptr <= ptr_inc(wptr);
            end
            if (do_pop) begin
                rptr <= ptr_inc(rptr);
            end
            unique case (1'b1)
                do_push & ~do_pop: cnt <= cnt + CntW'(1);
                do_pop & ~do_push: cnt <= cnt - CntW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/serial_link_obi_arbiter.sv
// Round-robin OBI arbiter in front of the serial-link slave port.
// Locks the presented master until granted; routes responses in order.
module serial_link_obi_arbiter
    import serial_link_obi_arb_pkg::*;
#(
    parameter int unsigned NumReq         = 2,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 2,
    localparam int unsigned BeWidth  = DataWidth / 8,
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NumReq-1:0]                  req_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]   addr_i,
    input  logic [NumReq-1:0]                  we_i,
    input  logic [NumReq-1:0][BeWidth-1:0]     be_i,
    input  logic [NumReq-1:0][DataWidth-1:0]   wdata_i,
    output logic [NumReq-1:0]                  gnt_o,
    output logic [NumReq-1:0]                  rvalid_o,
    output logic [DataWidth-1:0]               rdata_o,
    output logic                               req_o,
    output logic [AddrWidth-1:0]               addr_o,
    output logic                               we_o,
    output logic [BeWidth-1:0]                 be_o,
    output logic [DataWidth-1:0]               wdata_o,
    input  logic                               gnt_i,
    input  logic                               rvalid_i,
    input  logic [DataWidth-1:0]               rdata_i,
    output logic [CntWidth-1:0]                outstanding_o,
    output logic                               err_o
);

    localparam int unsigned IdxW = idx_width(NumReq);

    logic [IdxW-1:0] rr_q;
    logic [IdxW-1:0] lock_idx_q;
    logic            lock_q;
    logic [IdxW-1:0] sel;
    logic [IdxW-1:0] sel_inc;
    logic [IdxW:0]   cand;
    logic            found;
    logic            hs;
    logic            pop;
    logic            full;
    logic            empty;
    logic [IdxW-1:0] head;

    always_comb begin
        sel   = rr_q;
        found = 1'b0;
        cand  = '0;
        if (lock_q) begin
            sel = lock_idx_q;
        end else begin
            for (int i = 0; i < NumReq; i++) begin
                cand = {1'b0, rr_q} + (IdxW + 1)'(i);
                if (cand >= (IdxW + 1)'(NumReq)) begin
                    cand = cand - (IdxW + 1)'(NumReq);
                end
                if (!found && req_i[cand[IdxW-1:0]]) begin
                    sel   = cand[IdxW-1:0];
                    found = 1'b1;
                end
            end
        end
    end

    // full is registered occupancy, so rvalid_i never reaches req_o/gnt_o
    assign req_o   = rst_ni & req_i[sel] & ~full;
    assign hs      = req_o & gnt_i;
    assign pop     = rst_ni & rvalid_i & ~empty;
    assign sel_inc = (sel == IdxW'(NumReq - 1)) ? '0 : sel + IdxW'(1);

    assign addr_o  = addr_i[sel];
    assign we_o    = we_i[sel];
    assign be_o    = be_i[sel];
    assign wdata_o = wdata_i[sel];
    assign rdata_o = rdata_i;

    always_comb begin
        gnt_o         = '0;
        gnt_o[sel]    = hs;
        rvalid_o      = '0;
        rvalid_o[head] = pop;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_o      <= 1'b0;
        end else begin
            if (hs) begin
                rr_q   <= sel_inc;
                lock_q <= 1'b0;
            end else if (req_i[sel]) begin
                lock_q     <= 1'b1;
                lock_idx_q <= sel;
            end
            if (rvalid_i && empty) begin
                err_o <= 1'b1;
            end
        end
    end

    serial_link_obi_arb_idq #(
        .Depth (MaxOutstanding),
        .Width (IdxW)
    ) i_idq (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (hs),
        .pop    (pop),
        .wdata  (sel),
        .head   (head),
        .full   (full),
        .empty  (empty),
        .count  (outstanding_o)
    );

endmodule

// File: doc/serial_link_obi_arbiter.md
Name: serial_link_obi_arbiter

Overview:
- Shares the single OBI slave port of the X-HEEP serial-link wrapper between NumReq OBI masters (e.g. CPU data port and DMA).
- Arbitration is round-robin with a lock while a request is pending.
- Tracks up to MaxOutstanding in-flight transactions in an in-order ID queue and routes each rvalid/rdata back to its issuing master.
- Sits directly upstream of the wrapper's OBI-to-AXI-Lite bridge, which holds 2 requests in flight.

Parameters:
- NumReq, 2, number of requesting OBI masters (>=2).
- AddrWidth, 32, OBI address width.
- DataWidth, 32, OBI data width; be width = DataWidth/8.
- MaxOutstanding, 2, depth of the in-flight ID queue (>=1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- req_i  in  NumReq  per-master OBI req.
- addr_i  in  NumReq x AddrWidth  per-master address.
- we_i  in  NumReq  per-master write enable.
- be_i  in  NumReq x DataWidth/8  per-master byte enables.
- wdata_i  in  NumReq x DataWidth  per-master write data.
- gnt_o  out  NumReq  per-master grant.
- rvalid_o  out  NumReq  per-master response valid.
- rdata_o  out  DataWidth  response data, broadcast to all masters.
- req_o  out  1  downstream OBI req.
- addr_o  out  AddrWidth  downstream address.
- we_o  out  1  downstream write enable.
- be_o  out  DataWidth/8  downstream byte enables.
- wdata_o  out  DataWidth  downstream write data.
- gnt_i  in  1  downstream grant.
- rvalid_i  in  1  downstream response valid.
- rdata_i  in  DataWidth  downstream response data.
- outstanding_o  out  $clog2(MaxOutstanding+1)  in-flight count.
- err_o  out  1  sticky: rvalid_i received with an empty queue.

Behaviour:
- Reset (rst_ni low at a clk_i edge):
  - rr pointer = 0, lock = 0, queue empty, outstanding_o = 0, err_o = 0.
  - Combinationally: gnt_o = 0, rvalid_o = 0, req_o = 0.
  - Reset mid-transaction drops all in-flight IDs; responses arriving afterwards set err_o.
- full = (outstanding == MaxOutstanding).
- Selection:
  - If lock = 1, sel = locked index.
  - Otherwise sel = first index with req_i set, searching from the rr pointer upward with wrap at NumReq-1 -> 0.
- req_o = req_i[sel] & ~full. addr_o, we_o, be_o and wdata_o are a combinational mux of sel.
- No combinational path from rvalid_i to req_o or gnt_o. When full, a pop in the same cycle does not unblock grant until the next cycle.
- gnt_o[sel] = gnt_i & req_o; all other gnt_o bits are 0.
- Handshake (req_o & gnt_i), on that edge:
  - Push sel into the ID queue.
  - rr pointer = (sel+1) mod NumReq.
  - lock = 0.
- Lock:
  - Set when req_o & ~gnt_i; lock index = sel.
  - Held until handshake. Guarantees OBI stability: the presented master cannot be swapped before its grant.
  - Lock also holds across a full stall if req_i[sel] was already driven.
- Response:
  - rvalid_i with queue non-empty: rvalid_o[head] = 1 in the same cycle, rdata_o = rdata_i, pop on the edge.
  - rvalid_i with queue empty: no rvalid_o; err_o set, cleared only by reset.
- Simultaneous push and pop (not full): outstanding unchanged, FIFO order preserved.
- Latency: zero-cycle combinational request and response paths; the arbiter adds no register stage.
- outstanding_o = queue occupancy (registered). Increment on push, decrement on pop; never exceeds MaxOutstanding and never underflows.
- Single requester asserting: granted on the first cycle gnt_i is high (no bubble).

Decomposition:
- Package serial_link_obi_arb_pkg:
  - IdxWidth = $clog2(NumReq) helper function.
  - obi_flat_req_t / obi_flat_rsp_t typedefs, parametrised by address/data width via localparams.
- Sub-module serial_link_obi_arb_idq: synchronous FIFO of IdxWidth-bit IDs.
  - Ports: push, pop, wdata, head, full, empty, count.
  - Depth MaxOutstanding, with wrap-around read/write pointers.
- Arbiter logic (pointer, lock, mux) stays in the top.

Test Plan:
- Both masters request every cycle, gnt_i = 1, rvalid_i one cycle after each grant -> grants alternate 0,1,0,1; rdata 0xA5A5_0001 routed to master 0 and 0xA5A5_0002 to master 1 in order.
- Master 1 requests, gnt_i held low 3 cycles while master 0 asserts req -> addr_o stays master 1's 0x2000_0010 throughout; gnt_o[1] pulses on cycle 4, then master 0 is granted next.
- Two grants with no responses (MaxOutstanding = 2) -> req_o = 0 and outstanding_o = 2. rvalid_i in cycle N -> req_o re-asserts in cycle N+1, not N.
- Push and pop in the same cycle with outstanding = 1 -> outstanding_o stays 1; the next response goes to the correct older ID.
- rvalid_i = 1 with empty queue -> rvalid_o = 0, err_o = 1 and it remains 1 until rst_ni = 0 at a clk_i edge.
- Reset asserted with 2 outstanding, released -> outstanding_o = 0, rr pointer = 0, master 0 wins the first simultaneous request.
